uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 71 +++++++
 rtl/uart_byte_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_byte_rx.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit sides.
// Defining UART_RX_PARITY_EN adds the receive PARITY state to the encoding.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF = 16;
   localparam int unsigned FIFO_DEPTH_DEF   = 2;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef UART_RX_PARITY_EN
      StParity = 3'd4,
`endif
      StStop   = 3'd3
   } uart_state_e;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive byte buffer: push/pop, full/empty flags and a zero-when-empty head.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] data_i,
   output logic [7:0] head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned PtrW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FullCnt);
   assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

   always_comb begin
      pop_ok   = pop_i && !empty_o;
      push_ok  = push_i && (!full_o || pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CntW'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with mid-bit sampling and a small output buffer.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       rx_enable,
   input  logic       rx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data_out,
   output logic       frame_err,
   output logic       overrun_err
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   // Counter counts down to zero, so a load of N-1 expires N cycles later.
   localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);

   logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
   uart_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            push_q, push_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic            parity_err_q, parity_err_d;
`endif

   logic            fall, baud_tick;
   logic            fifo_full, fifo_empty, pop;

   assign fall      = rxd_prev_q && !rxd_sync_q;
   assign baud_tick = (cnt_q == '0);
   assign rx_valid  = !fifo_empty;
   assign pop       = rx_valid && rx_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = parity_err_q;
`endif
      if (state_q != StIdle && !baud_tick) begin
         cnt_d = cnt_q - CntW'(1);
      end
      unique case (state_q)
         StIdle: begin
            if (rx_enable && fall) begin
               state_d = StStart;
               cnt_d   = HalfLoad;
            end
         end
         StStart: begin
            if (baud_tick) begin
               if (!rxd_sync_q) begin
                  state_d   = StData;
                  cnt_d     = FullLoad;
                  bit_cnt_d = 3'd0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (baud_tick) begin
               shift_d   = {rxd_sync_q, shift_q[7:1]};
               cnt_d     = FullLoad;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (baud_tick) begin
               parity_err_d = (rxd_sync_q != even_parity(shift_q));
               cnt_d        = FullLoad;
               state_d      = StStop;
            end
         end
`endif
         StStop: begin
            if (baud_tick) begin
               state_d = StIdle;
`ifdef UART_RX_PARITY_EN
               if (rxd_sync_q && !parity_err_q) begin
`else
               if (rxd_sync_q) begin
`endif
                  push_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Disable aborts any frame in flight without reporting it.
      if (!rx_enable) begin
         state_d     = StIdle;
         cnt_d       = '0;
         bit_cnt_d   = 3'd0;
         push_d      = 1'b0;
         frame_err_d = 1'b0;
      end
      overrun_d = push_q && fifo_full && !pop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta_q   <= 1'b1;
         rxd_sync_q   <= 1'b1;
         rxd_prev_q   <= 1'b1;
         state_q      <= StIdle;
         cnt_q        <= '0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         push_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         rxd_meta_q   <= rxd;
         rxd_sync_q   <= rxd_meta_q;
         rxd_prev_q   <= rxd_sync_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         push_q       <= push_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_q;

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_q),
      .pop_i   (pop),
      .data_i  (shift_q),
      .head_o  (rx_data_out),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed scenarios plus randomized frames
// checked against an in-order delivery model.
module tb_uart_byte_rx;

   localparam int unsigned CPB   = 16;
   localparam int unsigned DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic       rx_enable = 1'b0;
   logic       rx_ready = 1'b0;
   logic       rx_valid;
   logic [7:0] rx_data_out;
   logic       frame_err;
   logic       overrun_err;

   int tests_run = 0;
   int tests_failed = 0;

   int         cyc = 0;
   logic [7:0] got_q[$];
   int         got_cyc_q[$];
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         valid_cnt = 0;
   int         stray_cnt = 0;

   uart_byte_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rxd         (rxd),
      .rx_enable   (rx_enable),
      .rx_ready    (rx_ready),
      .rx_valid    (rx_valid),
      .rx_data_out (rx_data_out),
      .frame_err   (frame_err),
      .overrun_err (overrun_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observer: records accepted bytes and counts pulse/valid cycles.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data_out);
            got_cyc_q.push_back(cyc);
         end
         if (frame_err) fe_cnt <= fe_cnt + 1;
         if (overrun_err) ov_cnt <= ov_cnt + 1;
         if (rx_valid) valid_cnt <= valid_cnt + 1;
         if (!rx_valid && rx_data_out !== 8'h00) stray_cnt <= stray_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d bytes, required completion",
               got_q.size());
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      step(CPB);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_raw(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_raw(d, ^d, stop);
   endtask
`else
   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
      rxd = 1'b1;
   endtask
`endif

   task automatic wait_count(input int target, input int budget, output bit ok);
      int n = 0;
      while (got_q.size() < target && n < budget) begin
         step(1);
         n++;
      end
      ok = (got_q.size() >= target);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rxd = 1'b1;
      rx_enable = 1'b0;
      rx_ready = 1'b1;
      step(3);
      tests_run++;
      if (rx_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid: got %b, expected 0", rx_valid);
      end
      tests_run++;
      if (rx_data_out !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data: got %h, expected 00", rx_data_out);
      end
      tests_run++;
      if (frame_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_frame_err: got %b, expected 0", frame_err);
      end
      tests_run++;
      if (overrun_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_overrun_err: got %b, expected 0", overrun_err);
      end
      rst = 1'b0;
      step(2);
      rx_enable = 1'b1;
      step(4);
   endtask

   task automatic test_basic();
      int base = got_q.size();
      int fe0 = fe_cnt;
      int v0 = valid_cnt;
      int start;
      bit ok;
      rx_ready = 1'b1;
      start = cyc;
      send_frame(8'hA5, 1'b1);
      wait_count(base + 1, 40, ok);
      step(10);
      tests_run++;
      if (!ok || got_q.size() != base + 1) begin
         tests_failed++;
         $display("FAIL basic_count: got %0d bytes, expected 1", got_q.size() - base);
      end else begin
         tests_run++;
         if (got_q[base] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL basic_data: got %h, expected a5", got_q[base]);
         end
         tests_run++;
         if (got_cyc_q[base] - start > 10 * 16 + 4) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles, expected <= 164",
                     got_cyc_q[base] - start);
         end
      end
      tests_run++;
      if (valid_cnt - v0 != 1) begin
         tests_failed++;
         $display("FAIL basic_valid_cycles: got %0d, expected 1", valid_cnt - v0);
      end
      tests_run++;
      if (fe_cnt != fe0) begin
         tests_failed++;
         $display("FAIL basic_frame_err: got %0d pulses, expected 0", fe_cnt - fe0);
      end
   endtask

   task automatic test_glitch();
      int base = got_q.size();
      int fe0 = fe_cnt;
      int v0 = valid_cnt;
      bit ok;
      rx_ready = 1'b1;
      rxd = 1'b0;
      step(6);
      rxd = 1'b1;
      step(40);
      tests_run++;
      if (valid_cnt != v0) begin
         tests_failed++;
         $display("FAIL glitch_valid: got %0d valid cycles, expected 0", valid_cnt - v0);
      end
      tests_run++;
      if (fe_cnt != fe0) begin
         tests_failed++;
         $display("FAIL glitch_frame_err: got %0d pulses, expected 0", fe_cnt - fe0);
      end
      // A clean frame right after shows the receiver returned to idle.
      send_frame(8'h96, 1'b1);
      wait_count(base + 1, 40, ok);
      tests_run++;
      if (!ok || got_q[base] !== 8'h96) begin
         tests_failed++;
         $display("FAIL glitch_recover: got %0d bytes, expected one byte 96", got_q.size() - base);
      end
      step(10);
   endtask

   task automatic test_frame_err();
      int base = got_q.size();
      int fe0 = fe_cnt;
      int v0 = valid_cnt;
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b0);
      step(30);
      tests_run++;
      if (fe_cnt - fe0 != 1) begin
         tests_failed++;
         $display("FAIL frame_err_pulse: got %0d cycles, expected 1", fe_cnt - fe0);
      end
      tests_run++;
      if (valid_cnt != v0 || got_q.size() != base) begin
         tests_failed++;
         $display("FAIL frame_err_valid: got %0d valid cycles, expected 0", valid_cnt - v0);
      end
   endtask

   task automatic test_overrun();
      int base = got_q.size();
      int ov0 = ov_cnt;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      step(2);
      send_frame(8'h22, 1'b1);
      step(2);
      send_frame(8'h33, 1'b1);
      step(20);
      tests_run++;
      if (ov_cnt - ov0 != 1) begin
         tests_failed++;
         $display("FAIL overrun_pulse: got %0d cycles, expected 1", ov_cnt - ov0);
      end
      tests_run++;
      if (rx_valid !== 1'b1 || rx_data_out !== 8'h11) begin
         tests_failed++;
         $display("FAIL overrun_head: got valid %b data %h, expected 1 11", rx_valid, rx_data_out);
      end
      rx_ready = 1'b1;
      step(6);
      tests_run++;
      if (got_q.size() != base + 2) begin
         tests_failed++;
         $display("FAIL overrun_count: got %0d bytes, expected 2", got_q.size() - base);
      end else begin
         tests_run++;
         if (got_q[base] !== 8'h11 || got_q[base + 1] !== 8'h22) begin
            tests_failed++;
            $display("FAIL overrun_order: got %h %h, expected 11 22", got_q[base], got_q[base + 1]);
         end
      end
      tests_run++;
      if (rx_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL overrun_drained: got valid %b, expected 0", rx_valid);
      end
   endtask

   task automatic test_enable_abort();
      int base = got_q.size();
      int fe0 = fe_cnt;
      logic [7:0] d = 8'h81;
      bit ok;
      rx_ready = 1'b1;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      rx_enable = 1'b0;
      for (int i = 4; i < 8; i++) send_bit(d[i]);
      send_bit(1'b1);
      step(20);
      rx_enable = 1'b1;
      step(5);
      send_frame(8'h5A, 1'b1);
      wait_count(base + 1, 40, ok);
      step(30);
      tests_run++;
      if (got_q.size() != base + 1 || got_q[base] !== 8'h5A) begin
         tests_failed++;
         $display("FAIL enable_abort_data: got %0d bytes, expected only 5a", got_q.size() - base);
      end
      tests_run++;
      if (fe_cnt != fe0) begin
         tests_failed++;
         $display("FAIL enable_abort_frame_err: got %0d pulses, expected 0", fe_cnt - fe0);
      end
   endtask

   task automatic test_reset_midframe();
      int base = got_q.size();
      int fe0 = fe_cnt;
      int ov0 = ov_cnt;
      bit ok;
      rx_ready = 1'b1;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b1;
      step(3);
      rxd = 1'b1;
      tests_run++;
      if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: got valid %b frame_err %b, expected 0 0",
                  rx_valid, frame_err);
      end
      rst = 1'b0;
      step(200);
      tests_run++;
      if (got_q.size() != base || fe_cnt != fe0 || ov_cnt != ov0) begin
         tests_failed++;
         $display("FAIL midreset_silent: got %0d bytes %0d fe %0d ov, expected 0 0 0",
                  got_q.size() - base, fe_cnt - fe0, ov_cnt - ov0);
      end
      send_frame(8'hC3, 1'b1);
      wait_count(base + 1, 40, ok);
      tests_run++;
      if (!ok || got_q[base] !== 8'hC3) begin
         tests_failed++;
         $display("FAIL midreset_recover: got %0d bytes, expected one byte c3", got_q.size() - base);
      end
      step(10);
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      int  fe_exp = 0;
      int  base = got_q.size();
      int  fe0 = fe_cnt;
      int  ov0 = ov_cnt;
      bit  done = 1'b0;
      bit  ok;
      fork
         begin
            for (int i = 0; i < 14; i++) begin
               logic [7:0] d;
               logic       stop;
               d = 8'($urandom);
               stop = ($urandom_range(0, 3) != 0);
               send_frame(d, stop);
               if (stop) exp_q.push_back(d);
               else fe_exp++;
               step(int'($urandom_range(1, 20)));
            end
            step(30);
            done = 1'b1;
         end
         begin
            while (!done) begin
               rx_ready = 1'($urandom_range(0, 1));
               step(1);
            end
            rx_ready = 1'b1;
         end
      join
      wait_count(base + exp_q.size(), 50, ok);
      step(5);
      tests_run++;
      if (got_q.size() != base + exp_q.size()) begin
         tests_failed++;
         $display("FAIL random_count: got %0d bytes, expected %0d", got_q.size() - base, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            tests_run++;
            if (got_q[base + i] !== exp_q[i]) begin
               tests_failed++;
               $display("FAIL random_data[%0d]: got %h, expected %h", i, got_q[base + i], exp_q[i]);
            end
         end
      end
      tests_run++;
      if (fe_cnt - fe0 != fe_exp) begin
         tests_failed++;
         $display("FAIL random_frame_err: got %0d pulses, expected %0d", fe_cnt - fe0, fe_exp);
      end
      tests_run++;
      if (ov_cnt != ov0) begin
         tests_failed++;
         $display("FAIL random_overrun: got %0d pulses, expected 0", ov_cnt - ov0);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int base = got_q.size();
      int fe0 = fe_cnt;
      bit ok;
      rx_ready = 1'b1;
      send_raw(8'h07, 1'b1, 1'b1);
      wait_count(base + 1, 40, ok);
      step(10);
      tests_run++;
      if (!ok || got_q[base] !== 8'h07) begin
         tests_failed++;
         $display("FAIL parity_good: got %0d bytes, expected one byte 07", got_q.size() - base);
      end
      send_raw(8'h07, 1'b0, 1'b1);
      step(30);
      tests_run++;
      if (got_q.size() != base + 1 || fe_cnt - fe0 != 1) begin
         tests_failed++;
         $display("FAIL parity_bad: got %0d bytes %0d fe, expected 0 1",
                  got_q.size() - base - 1, fe_cnt - fe0);
      end
   endtask
`endif

   task automatic test_empty_data();
      tests_run++;
      if (stray_cnt != 0) begin
         tests_failed++;
         $display("FAIL empty_data_zero: got %0d nonzero cycles, expected 0", stray_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_enable_abort();
      test_reset_midframe();
      test_random();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_empty_data();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
